// File: rtl/input_controller.sv
`default_nettype none
// ============================================================================
// Module   : input_controller
// Purpose  : Operator input handshake. It synchronizes and debounces the enter
//            pushbutton, then captures the switch word into dataIN on request.
// Option   : INPUT_SIGN_EXTEND_EN sign-extends switches[14] into dataIN[31:15].
//            Without it, those bits are zero-filled.
// Revision : 1.0 - initial release
// ============================================================================
module input_controller #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enter,
  input  logic [14:0] switches,
  input  logic        request,
  output logic [31:0] dataIN,
  output logic        ready,
  output logic        waiting
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, RELEASE, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             sync1;
  logic             sync2;
  logic             db_level;
  logic             db_level_prev;
  logic [CNT_W-1:0] db_cnt;
  logic             press_evt;
  logic             capture;
  logic [31:0]      ext_word;

`ifdef INPUT_SIGN_EXTEND_EN
  assign ext_word = {{17{switches[14]}}, switches};
`else
  assign ext_word = {17'd0, switches};
`endif

  // Both synchronizer stages and the debounced level reset to released (1).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= enter;
      sync2 <= sync1;
    end
  end

  // The counter only runs while a level change is pending. A glitch that
  // returns to the debounced level clears the counter before it can finish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_level      <= 1'b1;
      db_level_prev <= 1'b1;
      db_cnt        <= '0;
    end else begin
      db_level_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press_evt = db_level_prev & ~db_level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dataIN <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        dataIN <= ext_word;
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    ready      = 1'b0;
    waiting    = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        waiting = 1'b1;
        if (press_evt) begin
          capture    = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (db_level) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire
